serial_collector: RTL and testbench
===================================

SERIAL_COLLECTOR -- requirements
Module: serial_collector

Interface
REQ-001 SHALL have parameter: OUTPUT_WIDTH, 16, number of bits per word; legal range 2..64.
REQ-002 SHALL have port: fast_clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: serial_in  input  1  serial data bit, LSB first.
REQ-005 SHALL have port: serial_valid  input  1  high = serial_in holds a valid bit this cycle.
REQ-006 SHALL have port: data_ready  input  1  downstream accepts data_out this cycle.
REQ-007 SHALL have port: data_out  output  OUTPUT_WIDTH  assembled parallel word.
REQ-008 SHALL have port: data_valid  output  1  data_out holds a complete word.
REQ-009 SHALL have port: busy  output  1  word assembly in progress.
REQ-010 SHALL have port: frame_error  output  1  one-cycle pulse, word aborted short.
REQ-011 SHALL have port: overrun  output  1  one-cycle pulse, bit dropped while holding.
REQ-012 SHALL, as already decided, use one clock; reset is asynchronous and active-high.

Function
REQ-013 SHALL implement states IDLE, SHIFT, HOLD; bit counter width $clog2(OUTPUT_WIDTH)+1.
REQ-014 IDLE, serial_valid=1: SHALL write serial_in to bit 0, counter=1, go SHIFT.
REQ-015 IDLE, serial_valid=0: SHALL stay IDLE; data_out retains last value.
REQ-016 SHIFT, serial_valid=1: SHALL write serial_in to bit[counter], counter+1.
REQ-017 SHIFT, OUTPUT_WIDTH-th bit sampled: SHALL go HOLD, data_valid=1 the next cycle (latency 1 cycle after last bit).
REQ-018 SHIFT, serial_valid=0 before OUTPUT_WIDTH bits: SHALL pulse frame_error 1 cycle, discard partial word, clear counter, go IDLE; data_valid stays 0.
REQ-019 HOLD: data_out and data_valid SHALL remain stable until data_valid&&data_ready.
REQ-020 HOLD, handshake, serial_valid=0: SHALL go IDLE, data_valid=0 next cycle.
REQ-021 HOLD, handshake, serial_valid=1 same cycle: SHALL accept the bit as bit 0 of the next word, counter=1, go SHIFT; no overrun.
REQ-022 HOLD, no handshake, serial_valid=1: SHALL drop the bit, pulse overrun 1 cycle, and leave data_out unchanged.
REQ-023 busy SHALL be 1 exactly when state is SHIFT.
REQ-024 serial_in SHALL be ignored whenever serial_valid=0.
REQ-025 frame_error and overrun SHALL never assert in the same cycle.

Reset
REQ-026 On reset assertion: state=IDLE, counter=0, data_out=0, data_valid=0, busy=0, frame_error=0, overrun=0, immediately (asynchronous).
REQ-027 Reset mid-SHIFT or mid-HOLD SHALL discard the word without pulsing frame_error.
REQ-028 First capture after reset deassertion SHALL occur at the first rising edge with serial_valid=1.

Structure
REQ-029 State encoding and the default word-width constant SHALL live in the shared package.
REQ-030 SHALL be a single module; no sub-module is needed.

Verification (OUTPUT_WIDTH=16)
REQ-031 Send 0xA5C3 LSB first, 16 consecutive valid bits, data_ready=1 -> data_out=0xA5C3, data_valid=1 for exactly 1 cycle, 1 cycle after bit 15.
REQ-032 Send 0x1234, data_ready=0 for 10 cycles, then 1 -> data_valid and data_out=0x1234 held all 10 cycles, drop after the handshake.
REQ-033 Drop serial_valid after 5 bits -> frame_error pulses 1 cycle, data_valid stays 0; next full word 0xFFFF is received correctly.
REQ-034 In HOLD with data_ready=0, 3 extra valid bits -> 3 overrun pulses, data_out unchanged.
REQ-035 Two back-to-back words 0x00FF then 0xFF00 with data_ready=1 -> both delivered, no gap cycle, no overrun.
REQ-036 Assert reset after 8 bits of 0xBEEF -> all outputs 0 immediately, no frame_error; next word 0x0F0F is received correctly.

Source files
------------

// File: rtl/serial_collector_pkg.sv
// Shared types and constants for the serial-to-parallel word collector.
package serial_collector_pkg;

    localparam int DEFAULT_OUTPUT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    function automatic int cnt_width(input int word_w);
        return $clog2(word_w) + 1;
    endfunction

endpackage

// File: rtl/serial_collector_if.sv
// Serial input / parallel output bundle between a bit source, the collector and its sink.
interface serial_collector_if
    import serial_collector_pkg::*;
#(
    parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH
);
    logic                    serial_in;
    logic                    serial_valid;
    logic                    data_ready;
    logic [OUTPUT_WIDTH-1:0] data_out;
    logic                    data_valid;
    logic                    busy;
    logic                    frame_error;
    logic                    overrun;

    modport master (
        output serial_in, serial_valid, data_ready,
        input  data_out, data_valid, busy, frame_error, overrun
    );

    modport slave (
        input  serial_in, serial_valid, data_ready,
        output data_out, data_valid, busy, frame_error, overrun
    );
endinterface

// File: rtl/serial_collector.sv
// Assembles LSB-first serial bits into OUTPUT_WIDTH-bit words and holds each word
// until the downstream handshake; flags short words and bits lost while holding.
module serial_collector
    import serial_collector_pkg::*;
#(
    parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH
) (
    input  logic               fast_clk,
    input  logic               reset,
    serial_collector_if.slave  bus
);
    localparam int                CNT_W    = cnt_width(OUTPUT_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(OUTPUT_WIDTH - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [OUTPUT_WIDTH-1:0] shreg_q, shreg_d;
    logic [OUTPUT_WIDTH-1:0] data_q, data_d;
    logic                    frame_error_q, frame_error_d;
    logic                    overrun_q, overrun_d;

    logic [OUTPUT_WIDTH-1:0] bit_word;
    logic [OUTPUT_WIDTH-1:0] merged;

    always_comb begin
        bit_word = {{(OUTPUT_WIDTH-1){1'b0}}, bus.serial_in};
        merged   = shreg_q | (bit_word << cnt_q);

        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        data_d        = data_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.serial_valid) begin
                    shreg_d = bit_word;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.serial_valid) begin
                    shreg_d = merged;
                    if (cnt_q == LAST_IDX) begin
                        data_d  = merged;
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Stream stalled mid-word: the partial word is thrown away.
                    frame_error_d = 1'b1;
                    shreg_d       = '0;
                    cnt_d         = '0;
                    state_d       = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (bus.data_ready) begin
                    if (bus.serial_valid) begin
                        shreg_d = bit_word;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (bus.serial_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end
        endcase
    end

    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            data_q        <= '0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            data_q        <= data_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.data_out    = data_q;
    assign bus.data_valid  = (state_q == ST_HOLD);
    assign bus.busy        = (state_q == ST_SHIFT);
    assign bus.frame_error = frame_error_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_serial_collector.sv
// Directed bench for serial_collector: word-level reference model checked every cycle,
// plus literal expectations at the points of interest of each scenario.
module tb_serial_collector;
    import serial_collector_pkg::*;

    localparam int W = 16;

    logic fast_clk = 1'b0;
    logic reset    = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    serial_collector_if #(.OUTPUT_WIDTH(W)) bus ();

    serial_collector #(.OUTPUT_WIDTH(W)) dut (
        .fast_clk (fast_clk),
        .reset    (reset),
        .bus      (bus.slave)
    );

    always #5 fast_clk = ~fast_clk;

    // Reference model: bits gathered so far, whether a finished word awaits pickup,
    // and the last finished word.
    int           m_nbits = 0;
    logic [W-1:0] m_acc   = '0;
    logic         m_hold  = 1'b0;
    logic [W-1:0] m_last  = '0;
    logic         m_fe    = 1'b0;
    logic         m_ov    = 1'b0;

    always @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            m_nbits <= 0;
            m_acc   <= '0;
            m_hold  <= 1'b0;
            m_last  <= '0;
            m_fe    <= 1'b0;
            m_ov    <= 1'b0;
        end else begin : model_step
            int           n;
            logic [W-1:0] acc;
            logic [W-1:0] last;
            logic         hold;
            logic         fe;
            logic         ov;
            n    = m_nbits;
            acc  = m_acc;
            last = m_last;
            hold = m_hold;
            fe   = 1'b0;
            ov   = 1'b0;
            if (hold) begin
                if (bus.data_ready) begin
                    hold = 1'b0;
                    if (bus.serial_valid) begin
                        acc = W'(bus.serial_in);
                        n   = 1;
                    end
                end else if (bus.serial_valid) begin
                    ov = 1'b1;
                end
            end else if (n > 0) begin
                if (bus.serial_valid) begin
                    acc = acc + (W'(bus.serial_in) << n);
                    n   = n + 1;
                    if (n == W) begin
                        last = acc;
                        hold = 1'b1;
                        n    = 0;
                    end
                end else begin
                    fe  = 1'b1;
                    n   = 0;
                    acc = '0;
                end
            end else if (bus.serial_valid) begin
                acc = W'(bus.serial_in);
                n   = 1;
            end
            m_nbits <= n;
            m_acc   <= acc;
            m_last  <= last;
            m_hold  <= hold;
            m_fe    <= fe;
            m_ov    <= ov;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge fast_clk) begin
        if (!reset) begin
            check("model data_valid",  64'(bus.data_valid),  64'(m_hold));
            check("model busy",        64'(bus.busy),        64'(!m_hold && m_nbits > 0));
            check("model frame_error", 64'(bus.frame_error), 64'(m_fe));
            check("model overrun",     64'(bus.overrun),     64'(m_ov));
            check("model data_out",    64'(bus.data_out),    64'(m_last));
            check("fe_ov exclusive",   64'(bus.frame_error & bus.overrun), 64'd0);
        end
    end

    task automatic cyc(input logic sv, input logic b, input logic rdy);
        bus.serial_valid = sv;
        bus.serial_in    = b;
        bus.data_ready   = rdy;
        @(negedge fast_clk);
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic rdy);
        for (int i = 0; i < W; i++) cyc(1'b1, w[i], rdy);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " data_out"},    64'(bus.data_out),    64'd0);
        check({tag, " data_valid"},  64'(bus.data_valid),  64'd0);
        check({tag, " busy"},        64'(bus.busy),        64'd0);
        check({tag, " frame_error"}, 64'(bus.frame_error), 64'd0);
        check({tag, " overrun"},     64'(bus.overrun),     64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        bus.serial_valid = 1'b0;
        bus.serial_in    = 1'b0;
        bus.data_ready   = 1'b0;
        repeat (2) @(negedge fast_clk);
        check_all_zero("reset");
        #2 reset = 1'b0;

        // serial_in toggling without serial_valid must not start a word
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        check("idle busy", 64'(bus.busy), 64'd0);

        // full word, downstream always ready
        send_word(16'hA5C3, 1'b1);
        check("a5c3 valid", 64'(bus.data_valid), 64'd1);
        check("a5c3 data",  64'(bus.data_out),   64'hA5C3);
        cyc(1'b0, 1'b0, 1'b1);
        check("a5c3 valid one cycle", 64'(bus.data_valid), 64'd0);
        check("a5c3 data retained",   64'(bus.data_out),   64'hA5C3);

        // downstream stalls for 10 cycles
        send_word(16'h1234, 1'b0);
        check("1234 hold valid 0", 64'(bus.data_valid), 64'd1);
        check("1234 hold data 0",  64'(bus.data_out),   64'h1234);
        for (int i = 1; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            check("1234 hold valid", 64'(bus.data_valid), 64'd1);
            check("1234 hold data",  64'(bus.data_out),   64'h1234);
        end
        cyc(1'b0, 1'b0, 1'b1);
        check("1234 released", 64'(bus.data_valid), 64'd0);

        // short word: five bits then a gap
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1);
        check("short busy", 64'(bus.busy), 64'd1);
        cyc(1'b0, 1'b0, 1'b1);
        check("short frame_error", 64'(bus.frame_error), 64'd1);
        check("short no valid",    64'(bus.data_valid),  64'd0);
        cyc(1'b0, 1'b0, 1'b1);
        check("short fe one pulse", 64'(bus.frame_error), 64'd0);
        send_word(16'hFFFF, 1'b1);
        check("ffff data", 64'(bus.data_out), 64'hFFFF);
        cyc(1'b0, 1'b0, 1'b1);

        // bits arriving while a word is held are dropped
        send_word(16'h5A5A, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            check("overrun pulse",    64'(bus.overrun),  64'd1);
            check("overrun data",     64'(bus.data_out), 64'h5A5A);
        end
        cyc(1'b0, 1'b0, 1'b0);
        check("overrun cleared", 64'(bus.overrun), 64'd0);
        cyc(1'b0, 1'b0, 1'b1);

        // back-to-back words, new first bit shares the handshake cycle
        send_word(16'h00FF, 1'b1);
        check("b2b first valid", 64'(bus.data_valid), 64'd1);
        check("b2b first data",  64'(bus.data_out),   64'h00FF);
        send_word(16'hFF00, 1'b1);
        check("b2b second valid", 64'(bus.data_valid), 64'd1);
        check("b2b second data",  64'(bus.data_out),   64'hFF00);
        cyc(1'b0, 1'b0, 1'b1);

        // reset in the middle of a word
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'(16'hBEEF >> i), 1'b1);
        check("beef busy", 64'(bus.busy), 64'd1);
        #2 reset = 1'b1;
        #1 check_all_zero("async reset");
        @(negedge fast_clk);
        check_all_zero("reset held");
        #2 reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        check("post reset no fe", 64'(bus.frame_error), 64'd0);
        send_word(16'h0F0F, 1'b1);
        check("0f0f valid", 64'(bus.data_valid), 64'd1);
        check("0f0f data",  64'(bus.data_out),   64'h0F0F);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
